// File: rtl/pwm_multi_channel_if.sv
// Configuration and output bundle for pwm_multi_channel.
// PWM_CENTER_ALIGN_EN adds the center_mode setting.
interface pwm_multi_channel_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
);
    logic                  en;
    logic [PRE_W-1:0]      prescaler;
    logic [CNT_W-1:0]      period;
    logic [CH*CNT_W-1:0]   duty;
    logic [CH-1:0]         polarity;
    logic                  update;
`ifdef PWM_CENTER_ALIGN_EN
    logic                  center_mode;
`endif
    logic [CH-1:0]         pwm_out;
    logic                  period_tick;
    logic                  update_ack;

`ifdef PWM_CENTER_ALIGN_EN
    modport master (
        output en, prescaler, period, duty, polarity, update, center_mode,
        input  pwm_out, period_tick, update_ack
    );
    modport slave (
        input  en, prescaler, period, duty, polarity, update, center_mode,
        output pwm_out, period_tick, update_ack
    );
`else
    modport master (
        output en, prescaler, period, duty, polarity, update,
        input  pwm_out, period_tick, update_ack
    );
    modport slave (
        input  en, prescaler, period, duty, polarity, update,
        output pwm_out, period_tick, update_ack
    );
`endif
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with shared prescaler/period counter and boundary-synchronous shadow loads.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
module pwm_multi_channel #(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    pwm_multi_channel_if.slave bus
);
    logic [PRE_W-1:0]    pre_cnt_reg, pre_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [PRE_W-1:0]    pre_sh_reg, pre_act_reg;
    logic [CNT_W-1:0]    per_sh_reg, per_act_reg;
    logic [CH*CNT_W-1:0] duty_sh_reg, duty_act_reg;
    logic [CH-1:0]       pol_sh_reg, pol_act_reg;
    logic                pending_reg;
    logic [CH-1:0]       pwm_reg;
    logic                tick_reg, ack_reg;
    logic [CH-1:0]       cmp_hit;
    logic                step, at_end, boundary, load;

`ifdef PWM_CENTER_ALIGN_EN
    logic center_sh_reg, center_act_reg;
    logic dir_reg, dir_next;
    logic center_run, restart_center;

    // A zero period in center mode degenerates to edge-aligned counting.
    assign center_run     = center_act_reg && (per_act_reg != '0);
    assign restart_center = load ? (center_sh_reg && (per_sh_reg != '0)) : center_run;
    assign at_end         = center_run ? ((cnt_reg == '0) && dir_reg) : (cnt_reg == per_act_reg);
`else
    assign at_end = (cnt_reg == per_act_reg);
`endif

    assign step     = (pre_cnt_reg == pre_act_reg);
    assign boundary = bus.en && step && at_end;
    // While disabled there is no period to wait for, so a pending load happens at once.
    assign load     = pending_reg && (boundary || !bus.en);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_cmp
            assign cmp_hit[gi] = pol_act_reg[gi] ^ (cnt_reg < duty_act_reg[gi*CNT_W +: CNT_W]);
        end
    endgenerate

    always_comb begin
        pre_next = pre_cnt_reg + 1'b1;
        cnt_next = cnt_reg;
`ifdef PWM_CENTER_ALIGN_EN
        dir_next = dir_reg;
`endif
        if (!bus.en) begin
            pre_next = '0;
            cnt_next = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_next = 1'b0;
`endif
        end else if (step) begin
            pre_next = '0;
            if (boundary) begin
                cnt_next = '0;
`ifdef PWM_CENTER_ALIGN_EN
                // Center periods restart just past zero so zero is visited once per period.
                if (restart_center) begin
                    cnt_next = CNT_W'(1);
                end
                dir_next = 1'b0;
`endif
            end
`ifdef PWM_CENTER_ALIGN_EN
            else if (center_run) begin
                if (!dir_reg) begin
                    if (cnt_reg == per_act_reg) begin
                        cnt_next = cnt_reg - 1'b1;
                        dir_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`endif
            else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg  <= '0;
            cnt_reg      <= '0;
            pre_sh_reg   <= '0;
            pre_act_reg  <= '0;
            per_sh_reg   <= '0;
            per_act_reg  <= '0;
            duty_sh_reg  <= '0;
            duty_act_reg <= '0;
            pol_sh_reg   <= '0;
            pol_act_reg  <= '0;
            pending_reg  <= 1'b0;
            pwm_reg      <= '0;
            tick_reg     <= 1'b0;
            ack_reg      <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            center_sh_reg  <= 1'b0;
            center_act_reg <= 1'b0;
            dir_reg        <= 1'b0;
`endif
        end else begin
            pre_cnt_reg <= pre_next;
            cnt_reg     <= cnt_next;
            tick_reg    <= boundary;
            ack_reg     <= load;
            pwm_reg     <= bus.en ? cmp_hit : pol_act_reg;
`ifdef PWM_CENTER_ALIGN_EN
            dir_reg     <= dir_next;
`endif
            if (load) begin
                pre_act_reg  <= pre_sh_reg;
                per_act_reg  <= per_sh_reg;
                duty_act_reg <= duty_sh_reg;
                pol_act_reg  <= pol_sh_reg;
                pending_reg  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                center_act_reg <= center_sh_reg;
`endif
            end
            // Written after the load so an update in the same cycle stays pending.
            if (bus.update) begin
                pre_sh_reg  <= bus.prescaler;
                per_sh_reg  <= bus.period;
                duty_sh_reg <= bus.duty;
                pol_sh_reg  <= bus.polarity;
                pending_reg <= 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
                center_sh_reg <= bus.center_mode;
`endif
            end
        end
    end

    assign bus.pwm_out     = pwm_reg;
    assign bus.period_tick = tick_reg;
    assign bus.update_ack  = ack_reg;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a position-in-period reference model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_pwm_multi_channel;
    localparam int CH    = 4;
    localparam int CNT_W = 8;
    localparam int PRE_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_channel_if #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

    pwm_multi_channel #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [CH+1:0] exp_q [$];

    // Reference model: settings as integers, position t counted in clocks since period start.
    int       m_pre_sh, m_pre_act, m_per_sh, m_per_act;
    int       m_duty_sh [CH];
    int       m_duty_act [CH];
    logic [CH-1:0] m_pol_sh, m_pol_act;
    bit       m_ctr_sh, m_ctr_act, m_pend;
    int       m_t;
    int       mp, ms, mcnt, mlast;
    bit       mctr, e_tick, e_ack;
    logic [CH-1:0] e_pwm;

    task automatic m_clear();
        m_pre_sh = 0; m_pre_act = 0; m_per_sh = 0; m_per_act = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty_sh[i] = 0;
            m_duty_act[i] = 0;
        end
        m_pol_sh = '0; m_pol_act = '0;
        m_ctr_sh = 1'b0; m_ctr_act = 1'b0;
        m_pend = 1'b0; m_t = 0;
    endtask

    task automatic m_load();
        m_pre_act = m_pre_sh;
        m_per_act = m_per_sh;
        for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
        m_pol_act = m_pol_sh;
        m_ctr_act = m_ctr_sh;
        m_pend = 1'b0;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk);
            cycle++;
            if (!rst_n) begin
                m_clear();
                exp_q.push_back('0);
            end else begin
                if (!bus.en) begin
                    e_pwm  = m_pol_act;
                    e_tick = 1'b0;
                    e_ack  = m_pend;
                    if (m_pend) m_load();
                    m_t = 0;
                end else begin
                    mp    = m_pre_act + 1;
                    mctr  = m_ctr_act && (m_per_act != 0);
                    ms    = m_t / mp;
                    mcnt  = (mctr && ms > m_per_act) ? 2 * m_per_act - ms : ms;
                    mlast = mctr ? 2 * m_per_act : m_per_act;
                    for (int i = 0; i < CH; i++) e_pwm[i] = m_pol_act[i] ^ (mcnt < m_duty_act[i]);
                    e_tick = ((m_t % mp) == mp - 1) && (ms == mlast);
                    e_ack  = e_tick && m_pend;
                    if (e_tick) begin
                        if (m_pend) m_load();
                        m_t = (m_ctr_act && m_per_act != 0) ? (m_pre_act + 1) : 0;
                    end else begin
                        m_t++;
                    end
                end
                if (bus.update) begin
                    m_pre_sh = int'(bus.prescaler);
                    m_per_sh = int'(bus.period);
                    for (int i = 0; i < CH; i++) m_duty_sh[i] = int'(bus.duty[i*CNT_W +: CNT_W]);
                    m_pol_sh = bus.polarity;
`ifdef PWM_CENTER_ALIGN_EN
                    m_ctr_sh = bus.center_mode;
`else
                    m_ctr_sh = 1'b0;
`endif
                    m_pend = 1'b1;
                end
                exp_q.push_back({e_pwm, e_tick, e_ack});
            end
        end
    end

    initial begin
        logic [CH+1:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            got_v = {bus.pwm_out, bus.period_tick, bus.update_ack};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty cycle %0d got %b, no expected entry", cycle, got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb cycle %0d got pwm=%b tick=%b ack=%b expected pwm=%b tick=%b ack=%b",
                             cycle, got_v[CH+1:2], got_v[1], got_v[0], exp_v[CH+1:2], exp_v[1], exp_v[0]);
                end else if (got_v[0]) begin
                    $display("ack   cycle %0d pwm=%b", cycle, got_v[CH+1:2]);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int pre, input int per, input int d0, input int d1,
                           input int d2, input int d3, input logic [CH-1:0] pol);
        bus.prescaler = PRE_W'(pre);
        bus.period    = CNT_W'(per);
        bus.duty[0*CNT_W +: CNT_W] = CNT_W'(d0);
        bus.duty[1*CNT_W +: CNT_W] = CNT_W'(d1);
        bus.duty[2*CNT_W +: CNT_W] = CNT_W'(d2);
        bus.duty[3*CNT_W +: CNT_W] = CNT_W'(d3);
        bus.polarity  = pol;
    endtask

    task automatic pulse_update();
        $display("update cycle %0d pre=%0d per=%0d duty=%h pol=%b", cycle,
                 bus.prescaler, bus.period, bus.duty, bus.polarity);
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.pwm_out !== '0 || bus.period_tick !== 1'b0 || bus.update_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s got pwm=%b tick=%b ack=%b expected all 0", name,
                     bus.pwm_out, bus.period_tick, bus.update_ack);
        end
    endtask

    initial begin
        int pre, per, d [CH];
        bus.en = 1'b0;
        bus.update = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, '0);
`ifdef PWM_CENTER_ALIGN_EN
        bus.center_mode = 1'b0;
`endif
        #2 check_zero("reset_state");
        run(3);
        rst_n = 1'b1;
        run(2);

        // Basic load: period 10 clks, ch0 high 3
        bus.en = 1'b1;
        set_cfg(0, 9, 3, 5, 0, 9, 4'b0000);
        pulse_update();
        run(29);

        // Glitch-free duty change mid-period
        set_cfg(0, 9, 7, 5, 0, 9, 4'b0000);
        pulse_update();
        run(30);

        // Prescaled: tick every 12 clks, high 6 clks
        set_cfg(2, 3, 2, 2, 2, 2, 4'b0000);
        pulse_update();
        run(60);

        // Duty edges: 0, >period, inverted 0, mid value
        set_cfg(0, 200, 0, 255, 0, 100, 4'b0100);
        pulse_update();
        run(450);

        // Enable drop mid-period, with an update pending while disabled
        bus.en = 1'b0;
        run(3);
        set_cfg(0, 200, 0, 255, 0, 200, 4'b0101);
        pulse_update();
        run(3);
        bus.en = 1'b1;
        run(57);

        // Asynchronous reset mid-period
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        run(2);
        rst_n = 1'b1;
        run(5);

`ifdef PWM_CENTER_ALIGN_EN
        bus.center_mode = 1'b1;
        set_cfg(0, 4, 2, 0, 5, 4, 4'b0010);
        pulse_update();
        run(40);
        bus.center_mode = 1'b0;
`endif

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            pre = $urandom_range(0, 3);
            per = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < CH; i++)
                d[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, per + 2);
            set_cfg(pre, per, d[0], d[1], d[2], d[3], CH'($urandom_range(0, 15)));
`ifdef PWM_CENTER_ALIGN_EN
            bus.center_mode = $urandom_range(0, 1) == 1;
`endif
            run($urandom_range(0, 20));
            pulse_update();
            if ($urandom_range(0, 3) == 0) begin
                bus.duty[0 +: CNT_W] = CNT_W'($urandom_range(0, 255));
                pulse_update();
            end
            run($urandom_range(20, 80));
            if ($urandom_range(0, 5) == 0) begin
                bus.en = 1'b0;
                run($urandom_range(1, 5));
                bus.en = 1'b1;
            end
        end
        run(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
